// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall/flush/freeze sequencer for the 5-stage pipeline with data cache.
// Stall, flush and freeze outputs are combinational with zero latency.
// The cache-wait FSM and the miss watchdog are registered.
// Optional feature macro: HAZARD_PERF_CNT_EN enables the stall, freeze
// and flush performance counters. When it is undefined, those ports are
// tied to 0.
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fwd_en,
  input  logic [4:0]  src1_id,
  input  logic [4:0]  src2_id,
  input  logic        two_src_id,
  input  logic [4:0]  dst_exe,
  input  logic        wb_en_exe,
  input  logic        mem_read_exe,
  input  logic [4:0]  dst_mem,
  input  logic        wb_en_mem,
  input  logic        mem_req,
  input  logic        cache_ready,
  input  logic        branch_taken_exe,
  output logic        hold_pc,
  output logic        hold_ifid,
  output logic        bubble_idex,
  output logic        flush_ifid,
  output logic        freeze_all,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] freeze_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;
  logic             match_exe;
  logic             match_mem;
  logic             hazard;
  logic             freeze_raw;

  // A producer matches when it writes a non-zero register that ID reads.
  assign match_exe = (dst_exe != 5'd0) &&
                     ((dst_exe == src1_id) || (two_src_id && (dst_exe == src2_id)));
  assign match_mem = (dst_mem != 5'd0) &&
                     ((dst_mem == src1_id) || (two_src_id && (dst_mem == src2_id)));

  // With forwarding, only a load in EXE cannot be bypassed in time.
  assign hazard = fwd_en ? (mem_read_exe && wb_en_exe && match_exe)
                         : ((wb_en_exe && match_exe) || (wb_en_mem && match_mem));

  // State register
  // NOTE: state is updated with non-blocking assignments so that every
  // flop samples pre-edge values, whatever the order of the blocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_next;
  end

  // Next-state logic for the cache-wait FSM
  // NOTE: state_next is given a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      RUN:      if (mem_req && !cache_ready) state_next = MEM_WAIT;
      MEM_WAIT: if (cache_ready)             state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  // Output logic: freeze > branch > hazard, and everything is 0 in reset.
  // A reset asserted during MEM_WAIT clears state at once, so the
  // outputs are gated with rst as well.
  always_comb begin
    freeze_raw  = 1'b0;
    hold_pc     = 1'b0;
    hold_ifid   = 1'b0;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    case (state)
      RUN:      freeze_raw = mem_req && !cache_ready;
      MEM_WAIT: freeze_raw = !cache_ready;
      default:  freeze_raw = 1'b0;
    endcase
    freeze_all = rst && freeze_raw;
    if (rst && !freeze_raw) begin
      if (branch_taken_exe) begin
        flush_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end else if (hazard) begin
        hold_pc     = 1'b1;
        hold_ifid   = 1'b1;
        bubble_idex = 1'b1;
      end
    end
  end

  // The wait counter saturates at MAX_WAIT. The timeout bit is sticky
  // until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (state == MEM_WAIT) begin
      if (cache_ready) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_LIMIT) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt + 1'b1 == WAIT_LIMIT) timeout_q <= 1'b1;
      end
    end
  end

  assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  // Saturating performance counters that sample the live control outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles  <= '0;
      freeze_cycles <= '0;
      flush_count   <= '0;
    end else begin
      if (hold_pc && (stall_cycles != '1))     stall_cycles  <= stall_cycles + 1'b1;
      if (freeze_all && (freeze_cycles != '1)) freeze_cycles <= freeze_cycles + 1'b1;
      if (flush_ifid && (flush_count != '1))   flush_count   <= flush_count + 1'b1;
    end
  end
`else
  assign stall_cycles  = '0;
  assign freeze_cycles = '0;
  assign flush_count   = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl.
// Directed test-plan steps come first, then randomized cycles. All steps
// are compared against an event-level reference model of outstanding
// misses and hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        fwd_en, two_src_id, wb_en_exe, mem_read_exe, wb_en_mem;
  logic        mem_req, cache_ready, branch_taken_exe;
  logic [4:0]  src1_id, src2_id, dst_exe, dst_mem;
  logic        hold_pc, hold_ifid, bubble_idex, flush_ifid, freeze_all, mem_timeout;
  logic [31:0] stall_cycles, freeze_cycles;
  logic [15:0] flush_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: is a miss outstanding, how long it has waited, and
  // the event totals.
  bit      m_waiting;
  int      m_wait;
  bit      m_timeout;
  longint  m_stall, m_freeze, m_flush;

  pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en),
    .src1_id(src1_id), .src2_id(src2_id), .two_src_id(two_src_id),
    .dst_exe(dst_exe), .wb_en_exe(wb_en_exe), .mem_read_exe(mem_read_exe),
    .dst_mem(dst_mem), .wb_en_mem(wb_en_mem),
    .mem_req(mem_req), .cache_ready(cache_ready), .branch_taken_exe(branch_taken_exe),
    .hold_pc(hold_pc), .hold_ifid(hold_ifid), .bubble_idex(bubble_idex),
    .flush_ifid(flush_ifid), .freeze_all(freeze_all), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .freeze_cycles(freeze_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit reads_reg(input logic [4:0] d);
    return (d != 5'd0) && ((d == src1_id) || (two_src_id && (d == src2_id)));
  endfunction

  task automatic model_reset();
    m_waiting = 1'b0;
    m_wait    = 0;
    m_timeout = 1'b0;
    m_stall   = 0;
    m_freeze  = 0;
    m_flush   = 0;
  endtask

  task automatic clear_inputs();
    fwd_en = 1'b0; two_src_id = 1'b0; wb_en_exe = 1'b0; mem_read_exe = 1'b0;
    wb_en_mem = 1'b0; mem_req = 1'b0; cache_ready = 1'b0; branch_taken_exe = 1'b0;
    src1_id = '0; src2_id = '0; dst_exe = '0; dst_mem = '0;
  endtask

  // One cycle: check mid-cycle, then advance the model at the clock edge.
  task automatic tick(input string tag);
    bit e_freeze, e_haz, e_br, e_st;
    #3;
    e_freeze = rst && (m_waiting ? !cache_ready : (mem_req && !cache_ready));
    e_haz    = fwd_en ? (mem_read_exe && wb_en_exe && reads_reg(dst_exe))
                      : ((wb_en_exe && reads_reg(dst_exe)) || (wb_en_mem && reads_reg(dst_mem)));
    e_br     = rst && !e_freeze && branch_taken_exe;
    e_st     = rst && !e_freeze && !branch_taken_exe && e_haz;
    check({tag, ".hold_pc"},     32'(hold_pc),     32'(e_st));
    check({tag, ".hold_ifid"},   32'(hold_ifid),   32'(e_st));
    check({tag, ".bubble_idex"}, 32'(bubble_idex), 32'(e_st || e_br));
    check({tag, ".flush_ifid"},  32'(flush_ifid),  32'(e_br));
    check({tag, ".freeze_all"},  32'(freeze_all),  32'(e_freeze));
    check({tag, ".mem_timeout"}, 32'(mem_timeout), 32'(m_timeout));
`ifdef HAZARD_PERF_CNT_EN
    check({tag, ".stall_cycles"},  stall_cycles,        32'(m_stall));
    check({tag, ".freeze_cycles"}, freeze_cycles,       32'(m_freeze));
    check({tag, ".flush_count"},   32'(flush_count),    32'(m_flush));
`else
    check({tag, ".stall_cycles"},  stall_cycles,        32'd0);
    check({tag, ".freeze_cycles"}, freeze_cycles,       32'd0);
    check({tag, ".flush_count"},   32'(flush_count),    32'd0);
`endif
    @(posedge clk);
    if (rst) begin
      if (e_st     && m_stall  < 64'hFFFF_FFFF) m_stall++;
      if (e_freeze && m_freeze < 64'hFFFF_FFFF) m_freeze++;
      if (e_br     && m_flush  < 64'hFFFF)      m_flush++;
      if (m_waiting) begin
        if (cache_ready) begin
          m_waiting = 1'b0;
          m_wait    = 0;
        end else begin
          if (m_wait < MAX_WAIT) m_wait++;
          if (m_wait >= MAX_WAIT) m_timeout = 1'b1;
        end
      end else if (mem_req && !cache_ready) begin
        m_waiting = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    model_reset();
    tick("reset");
    rst = 1'b1;
    tick("idle");

    // Load-use with forwarding, then the same registers without a load
    fwd_en = 1'b1; mem_read_exe = 1'b1; wb_en_exe = 1'b1; dst_exe = 5'd5; src1_id = 5'd5;
    tick("load_use");
    mem_read_exe = 1'b0;
    tick("no_load");

    // No forwarding: MEM-stage producer read through src2
    clear_inputs();
    wb_en_mem = 1'b1; dst_mem = 5'd7; src2_id = 5'd7; two_src_id = 1'b1;
    tick("mem_src2");
    two_src_id = 1'b0;
    tick("mem_one_src");
    two_src_id = 1'b1; dst_mem = 5'd0;
    tick("mem_r0");

    // Cache miss of three cycles, then ready
    clear_inputs();
    mem_req = 1'b1; cache_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick("miss3");
    cache_ready = 1'b1;
    tick("miss3_done");
    mem_req = 1'b0;
    tick("after_miss");
    // Hit path costs no freeze
    mem_req = 1'b1;
    tick("hit");

    // Branch and load-use together, then the same inputs during a freeze
    clear_inputs();
    fwd_en = 1'b1; mem_read_exe = 1'b1; wb_en_exe = 1'b1; dst_exe = 5'd9; src1_id = 5'd9;
    branch_taken_exe = 1'b1;
    tick("branch_hazard");
    mem_req = 1'b1; cache_ready = 1'b0;
    tick("branch_freeze_run");
    tick("branch_freeze_wait");
    cache_ready = 1'b1;
    tick("branch_unfrozen");

    // Watchdog: ten wait cycles with MAX_WAIT = 4, sticky after ready
    clear_inputs();
    mem_req = 1'b1; cache_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick("watchdog");
    cache_ready = 1'b1;
    tick("watchdog_ready");
    mem_req = 1'b0;
    tick("watchdog_sticky");
    rst = 1'b0;
    model_reset();
    tick("watchdog_rst");
    rst = 1'b1;
    tick("watchdog_cleared");

    // Reset asserted while waiting on the cache
    mem_req = 1'b1; cache_ready = 1'b0;
    branch_taken_exe = 1'b1;
    tick("wait_enter");
    tick("wait_hold");
    rst = 1'b0;
    model_reset();
    tick("wait_rst");
    rst = 1'b1; mem_req = 1'b0;
    tick("wait_rst_release");
    branch_taken_exe = 1'b0;

    // Randomized traffic over a small register window to get frequent matches
    for (int i = 0; i < 400; i++) begin
      fwd_en           = 1'($urandom_range(0, 1));
      src1_id          = 5'($urandom_range(0, 3));
      src2_id          = 5'($urandom_range(0, 3));
      two_src_id       = 1'($urandom_range(0, 1));
      dst_exe          = 5'($urandom_range(0, 3));
      wb_en_exe        = 1'($urandom_range(0, 1));
      mem_read_exe     = 1'($urandom_range(0, 1));
      dst_mem          = 5'($urandom_range(0, 3));
      wb_en_mem        = 1'($urandom_range(0, 1));
      mem_req          = ($urandom_range(0, 2) == 0);
      cache_ready      = ($urandom_range(0, 9) < 6);
      branch_taken_exe = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b0;
        model_reset();
      end else begin
        rst = 1'b1;
      end
      tick("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline with data cache. Decides each cycle whether PC and IF/ID hold, whether a bubble enters ID/EXE, and whether the whole pipeline freezes while the cache services a miss. Sits beside the forwarding unit: it covers the hazards forwarding cannot resolve, and every RAW hazard when forwarding is off. Contains the cache-wait FSM, a miss-timeout watchdog and optional performance counters.

## Interface
- `MAX_WAIT`, 255: cache-wait cycles before `mem_timeout` sets; range 1..2^`CNT_W`-1.
- `CNT_W`, 8: width of the wait counter.

- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `fwd_en`  in  1  forwarding enabled (runtime).
- `src1_id`, `src2_id`  in  5 each  ID-stage source registers.
- `two_src_id`  in  1  instruction in ID reads `src2_id` (R-type or store).
- `dst_exe`, `wb_en_exe`, `mem_read_exe`  in  5/1/1  EXE destination, writeback enable, load flag.
- `dst_mem`, `wb_en_mem`  in  5/1  MEM destination, writeback enable.
- `mem_req`  in  1  MEM stage issues a cache load or store this cycle.
- `cache_ready`  in  1  cache completes the MEM-stage access this cycle.
- `branch_taken_exe`  in  1  branch resolved taken in EXE.
- `hold_pc`, `hold_ifid`  out  1  hold PC and the IF/ID register.
- `bubble_idex`  out  1  load a NOP into ID/EXE.
- `flush_ifid`  out  1  replace IF/ID with a NOP.
- `freeze_all`  out  1  hold every pipeline register (cache miss).
- `mem_timeout`  out  1  sticky watchdog error.
- `stall_cycles`, `freeze_cycles`  out  32 each  performance counters.
- `flush_count`  out  16  taken-branch flush counter.

## Operation
- FSM states: RUN (0), MEM_WAIT (1). Reset: RUN, wait counter 0, `mem_timeout` 0, all counters 0.
- RUN: if `mem_req` & !`cache_ready`, then `freeze_all`=1 this cycle and next state is MEM_WAIT. Otherwise `freeze_all`=0.
- MEM_WAIT: `freeze_all` = !`cache_ready`. The wait counter increments each cycle with `cache_ready`=0.
  - `cache_ready`=1: freeze drops in that same cycle, counter clears, next state is RUN.
- Watchdog: when the counter reaches `MAX_WAIT`, `mem_timeout` sets and stays set until reset. The counter saturates and the FSM keeps waiting.
- RAW hazard. A match is a non-zero destination equal to `src1_id`, or equal to `src2_id` when `two_src_id`=1.
  - `fwd_en`=1: hazard = `mem_read_exe` & `wb_en_exe` & match on `dst_exe` (load-use).
  - `fwd_en`=0: hazard = (`wb_en_exe` & match on `dst_exe`) | (`wb_en_mem` & match on `dst_mem`).
- Priority: freeze > branch > hazard.
  - `freeze_all`=1: `hold_pc`, `hold_ifid`, `bubble_idex` and `flush_ifid` are all 0. The freeze holds every register.
  - else `branch_taken_exe`=1: `flush_ifid`=1, `bubble_idex`=1, no hold.
  - else hazard: `hold_pc`=`hold_ifid`=`bubble_idex`=1.
- A branch or hazard seen during a freeze is re-evaluated on the first unfrozen cycle, because the pipeline contents are unchanged.

## Timing
- All stall, flush and freeze outputs are combinational from inputs and state, with zero-cycle latency. `mem_timeout` and the counters are registered.
- While `rst`=0, all outputs are forced to 0, whatever the inputs.
- Reset asserted in MEM_WAIT: return to RUN immediately; the counter and `mem_timeout` clear.
- Hit path: `mem_req`=1 and `cache_ready`=1 in the same cycle costs zero freeze cycles.
- A miss resolved N cycles after the request produces exactly N freeze cycles.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cycles` counts cycles with `hold_pc`=1.
  - `freeze_cycles` counts cycles with `freeze_all`=1.
  - `flush_count` counts cycles with `flush_ifid`=1.
  - All three saturate at their maximum and clear on reset.
- Macro not defined: the counter logic is omitted and all three ports are tied to 0.

## Test plan
- `fwd_en`=1, `mem_read_exe`=1, `wb_en_exe`=1, `dst_exe`=5, `src1_id`=5 -> `hold_pc`=`hold_ifid`=`bubble_idex`=1 for one cycle. Repeat with `mem_read_exe`=0 -> no stall.
- `fwd_en`=0, `wb_en_mem`=1, `dst_mem`=7, `src2_id`=7, `two_src_id`=1 -> stall. Same with `two_src_id`=0 -> no stall. `dst_mem`=0 -> no stall.
- `mem_req`=1 with `cache_ready` low for 3 cycles, then high -> `freeze_all`=1 for exactly 3 cycles, state returns to RUN, `freeze_cycles`=3 (macro defined).
- `branch_taken_exe`=1 together with a load-use hazard -> `flush_ifid`=1, `bubble_idex`=1, `hold_pc`=0. Same inputs during a freeze -> all four outputs 0.
- `MAX_WAIT`=4, `cache_ready` held low for 10 cycles -> `mem_timeout` sets on the 4th wait cycle and stays set after `cache_ready`. Pulse `rst` low -> `mem_timeout`=0, state RUN.
- `rst` pulled low while in MEM_WAIT with `mem_req`=1 -> all outputs 0 immediately. After release, the state is RUN and the counters are 0.
